pwm_demod: RTL and testbench



---
 rtl/pwm_demod.sv | 277 +++++++++++++++++++++++++++
 tb/tb_pwm_demod.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_demod.sv
// ---------------------------------------------------------------------------
// pwm_demod
//
// Purpose:
//   Receive end of the pwm generator. Samples an asynchronous PWM input,
//   measures the high time and the period in i_clk cycles, and reports one
//   (compare, top) pair per completed period with a single-cycle strobe.
//   An input that stays high or low for 2^COUNT_W-1 cycles without an edge
//   is reported as stuck. That report repeats for as long as the input
//   stays stuck.
//
// Parameters:
//   COUNT_W      width of the cycle counters and of o_compare / o_top
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_pwm        asynchronous PWM input
//   o_compare    measured high time in cycles (all ones / 0 on stuck high / low)
//   o_top        measured period minus 1 (all ones on stuck)
//   o_valid      one-cycle strobe: o_compare, o_top and o_stuck are new
//   o_stuck      qualified by o_valid: the report is a timeout, not a period
//
// Build option:
//   PWM_DEMOD_GLITCH_FILTER_EN  inserts a 3-sample majority filter after the
//                               synchronizer. This rejects single-cycle
//                               glitches and adds 2 cycles of latency.
//
// States:
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_ARM  | waiting for the first rising edge; no period in progress
//   ST_HIGH | inside the high phase of a period, counting high cycles
//   ST_LOW  | inside the low phase of a period, counting low cycles
// ---------------------------------------------------------------------------
module pwm_demod #(
    parameter int COUNT_W = 10
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pwm,
    output logic [COUNT_W-1:0] o_compare,
    output logic [COUNT_W-1:0] o_top,
    output logic               o_valid,
    output logic               o_stuck
);

    localparam logic [COUNT_W:0]   SUM_MAX  = {1'b0, {COUNT_W{1'b1}}};
    localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] CNT_ONES = {COUNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic               sync1_q, sync2_q;
    logic               s;
    logic               s_d_q;
    logic               rise, fall;

    logic [COUNT_W-1:0] high_q, high_d;
    logic [COUNT_W-1:0] low_q,  low_d;
    logic [COUNT_W:0]   sum;
    logic [COUNT_W-1:0] top_calc;
    logic               timeout;
    logic               publish;
    logic               tmo_pub;

    logic [COUNT_W-1:0] compare_q, compare_d;
    logic [COUNT_W-1:0] top_q,     top_d;
    logic               valid_q,   valid_d;
    logic               stuck_q,   stuck_d;

    // -----------------------------------------------------------------------
    // Input synchronizer
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= i_pwm;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_DEMOD_GLITCH_FILTER_EN
    logic hist1_q, hist2_q, filt_q;

    // The filtered level follows the majority of the three most recent
    // synchronized samples, so one odd sample never moves it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
            filt_q  <= (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
        end
    end

    assign s = filt_q;
`else
    assign s = sync2_q;
`endif

    // -----------------------------------------------------------------------
    // Edge detection
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s_d_q <= 1'b0;
        end else begin
            s_d_q <= s;
        end
    end

    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

    // The sum is one bit wider than the counters so that the timeout compare
    // cannot alias. The counters never pass SUM_MAX, so the published top
    // value fits in COUNT_W bits.
    assign sum      = {1'b0, high_q} + {1'b0, low_q};
    assign timeout  = (sum == SUM_MAX);
    assign top_calc = high_q + low_q - CNT_ONE;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_ARM;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // A rise takes priority over a simultaneous timeout. That lets a period
    // of exactly 2^COUNT_W-1 cycles be measured normally.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ARM: begin
                if (rise) begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (timeout) begin
                    state_d = ST_ARM;
                end else if (fall) begin
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_d = ST_HIGH;
                end else if (timeout) begin
                    state_d = ST_ARM;
                end
            end
            default: state_d = ST_ARM;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs (publish decision and next report values)
    // -----------------------------------------------------------------------
    always_comb begin
        publish   = (state_q == ST_LOW) && rise;
        tmo_pub   = timeout && !rise;
        valid_d   = 1'b0;
        compare_d = compare_q;
        top_d     = top_q;
        stuck_d   = stuck_q;
        if (publish) begin
            valid_d   = 1'b1;
            compare_d = high_q;
            top_d     = top_calc;
            stuck_d   = 1'b0;
        end else if (tmo_pub) begin
            valid_d   = 1'b1;
            compare_d = s ? CNT_ONES : '0;
            top_d     = CNT_ONES;
            stuck_d   = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Cycle counters
    // In ST_ARM no period is in progress. The counters then track the time
    // since the last edge, so that a stuck input is still caught. An edge
    // cycle and a timeout cycle both count as cycle 1 of the interval that
    // follows. This keeps stuck reports exactly 2^COUNT_W-1 cycles apart.
    // -----------------------------------------------------------------------
    always_comb begin
        high_d = high_q;
        low_d  = low_q;
        if (rise) begin
            high_d = CNT_ONE;
            low_d  = '0;
        end else if (tmo_pub) begin
            high_d = s ? CNT_ONE : '0;
            low_d  = s ? '0 : CNT_ONE;
        end else begin
            unique case (state_q)
                ST_ARM: begin
                    if (fall) begin
                        high_d = '0;
                        low_d  = CNT_ONE;
                    end else if (s) begin
                        high_d = high_q + CNT_ONE;
                    end else begin
                        low_d = low_q + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        low_d = CNT_ONE;
                    end else begin
                        high_d = high_q + CNT_ONE;
                    end
                end
                ST_LOW: begin
                    low_d = low_q + CNT_ONE;
                end
                default: begin
                    high_d = '0;
                    low_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            high_q <= '0;
            low_q  <= '0;
        end else begin
            high_q <= high_d;
            low_q  <= low_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            compare_q <= '0;
            top_q     <= '0;
            valid_q   <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            compare_q <= compare_d;
            top_q     <= top_d;
            valid_q   <= valid_d;
            stuck_q   <= stuck_d;
        end
    end

    assign o_compare = compare_q;
    assign o_top     = top_q;
    assign o_valid   = valid_q;
    assign o_stuck   = stuck_q;

endmodule

// File: tb/tb_pwm_demod.sv
`timescale 1ns/1ps
module tb_pwm_demod;

    localparam int CW   = 10;
    localparam int MAXV = (1 << CW) - 1;
`ifdef PWM_DEMOD_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    localparam int MIN_W = FILT ? 2 : 1;
    localparam int FOFF  = FILT ? 2 : 0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pwm;
    logic [CW-1:0] cmp;
    logic [CW-1:0] top;
    logic          valid;
    logic          stuck;

    pwm_demod #(.COUNT_W(CW)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_pwm     (pwm),
        .o_compare (cmp),
        .o_top     (top),
        .o_valid   (valid),
        .o_stuck   (stuck)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tick;
        int cmp;
        int top;
        int stk;
    } rpt_t;

    rpt_t exp_q[$];
    rpt_t cap_q[$];

    int errors = 0;
    int checks = 0;
    int tick   = 0;
    bit capture = 1'b0;
    int seg_rpts = 0;
    int last_cmp = 0;
    int last_top = 0;

    // Reference model state: the level the demodulator should see, and the
    // edge times of the period in progress.
    bit d1, d2, d3;
    bit prev_seen;
    bit armed;
    int rise_t, fall_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic bit maj3(input bit a, input bit b, input bit c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    task automatic model_reset();
        d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
        prev_seen = 1'b0;
        armed = 1'b0;
        rise_t = 0;
        fall_t = 0;
        exp_q.delete();
    endtask

    // One clock: observe the outputs, then drive the next input sample.
    task automatic step(input bit v);
        bit   seen;
        rpt_t r;
        rpt_t e;
        @(negedge clk);
        tick++;
        if (valid === 1'b1) begin
            seg_rpts++;
            last_cmp = int'(cmp);
            last_top = int'(top);
            r.tick = tick; r.cmp = int'(cmp); r.top = int'(top); r.stk = int'(stuck);
            if (capture) begin
                cap_q.push_back(r);
            end else if (exp_q.size() == 0) begin
                check("spurious_report_tick", tick, 0);
            end else begin
                e = exp_q.pop_front();
                check("report_tick", tick, e.tick);
                check("report_compare", cmp, e.cmp);
                check("report_top", top, e.top);
                check("report_stuck", stuck, e.stk);
            end
        end
        while (exp_q.size() > 0 && exp_q[0].tick < tick) begin
            e = exp_q.pop_front();
            check("missed_report_tick", tick, e.tick);
        end
        pwm = v;
        // The filtered build sees the majority of the three previous samples.
        seen = FILT ? maj3(d1, d2, d3) : v;
        d3 = d2; d2 = d1; d1 = v;
        if (seen && !prev_seen) begin
            if (armed) begin
                r.tick = tick + 3;
                r.cmp  = fall_t - rise_t;
                r.top  = tick - rise_t - 1;
                r.stk  = 0;
                exp_q.push_back(r);
            end
            armed  = 1'b1;
            rise_t = tick;
        end
        if (!seen && prev_seen) fall_t = tick;
        prev_seen = seen;
    endtask

    task automatic pwm_period(input int h, input int l);
        repeat (h) step(1'b1);
        repeat (l) step(1'b0);
    endtask

    task automatic check_stuck(input string tag, input int first_lo, input int first_hi,
                               input int exp_cmp);
        check({tag, "_count"}, cap_q.size(), 2);
        if (cap_q.size() == 2) begin
            check({tag, "_first_in_window"},
                  (cap_q[0].tick >= first_lo && cap_q[0].tick <= first_hi), 1);
            check({tag, "_spacing"}, cap_q[1].tick - cap_q[0].tick, MAXV);
            for (int i = 0; i < 2; i++) begin
                check({tag, "_compare"}, cap_q[i].cmp, exp_cmp);
                check({tag, "_top"}, cap_q[i].top, MAXV);
                check({tag, "_stuck"}, cap_q[i].stk, 1);
            end
        end
    endtask

    initial begin
        int r_t;
        int rel_t;

        rst_n = 1'b0;
        pwm   = 1'b0;
        model_reset();
        repeat (3) step(1'b0);
        check("reset_compare", cmp, 0);
        check("reset_top", top, 0);
        check("reset_valid", valid, 0);
        check("reset_stuck", stuck, 0);
        #2 rst_n = 1'b1;
        model_reset();
        repeat (5) step(1'b0);

        // Steady 64/256: reports begin at the second rising edge.
        seg_rpts = 0;
        repeat (5) pwm_period(64, 192);
        check("steady_report_count", seg_rpts, 4);

        // Duty sweep and the shortest decodable period.
        pwm_period(MIN_W, 256 - MIN_W);
        pwm_period(128, 128);
        pwm_period(256 - MIN_W, MIN_W);
        repeat (3) pwm_period(MIN_W, MIN_W);
        pwm_period(64, 192);

        // Random periods.
        repeat (24) pwm_period($urandom_range(200, MIN_W), $urandom_range(200, MIN_W));
        pwm_period(64, 192);

        // Longest measurable period, 1023 cycles.
        pwm_period(500, 523);
        repeat (8) step(1'b1);
        check("max_period_compare", last_cmp, 500);
        check("max_period_top", last_top, MAXV - 1);
        repeat (56) step(1'b1);
        repeat (192) step(1'b0);

        // Single-cycle low glitch inside a 64-cycle high.
        repeat (30) step(1'b1);
        step(1'b0);
        repeat (33) step(1'b1);
        repeat (192) step(1'b0);
        repeat (8) step(1'b1);
        check("glitch_compare", last_cmp, FILT ? 64 : 33);
        check("glitch_top", last_top, FILT ? 255 : 224);
        repeat (56) step(1'b1);
        repeat (192) step(1'b0);

        // Asynchronous reset in the middle of a high phase.
        repeat (20) step(1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_compare", cmp, 0);
        check("async_reset_top", top, 0);
        check("async_reset_valid", valid, 0);
        check("async_reset_stuck", stuck, 0);
        repeat (44) step(1'b1);
        repeat (10) step(1'b0);
        #2 rst_n = 1'b1;
        model_reset();
        seg_rpts = 0;
        pwm_period(64, 192);
        check("post_reset_no_report", seg_rpts, 0);
        pwm_period(64, 192);
        check("post_reset_one_report", seg_rpts, 1);
        pwm_period(64, 192);

        // Stuck low from reset, then recovery.
        repeat (3) step(1'b0);
        capture = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) step(1'b0);
        #2 rst_n = 1'b1;
        model_reset();
        rel_t = tick;
        cap_q.delete();
        repeat (2100) step(1'b0);
        capture = 1'b0;
        check_stuck("stuck_low", rel_t + MAXV - 3, rel_t + MAXV + 5, 0);
        seg_rpts = 0;
        repeat (3) pwm_period(64, 192);
        check("recovery_report_count", seg_rpts, 2);

        // Stuck high after one rising edge.
        step(1'b1);
        r_t = tick;
        repeat (10) step(1'b1);
        capture = 1'b1;
        cap_q.delete();
        repeat (2070) step(1'b1);
        repeat (20) step(1'b0);
        capture = 1'b0;
        armed = 1'b0;
        check_stuck("stuck_high", r_t + 3 + FOFF + MAXV - 3, r_t + 3 + FOFF + MAXV + 3, MAXV);

        repeat (3) pwm_period(64, 192);
        repeat (10) step(1'b0);
        check("pending_reports_at_end", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
